// File: rtl/host_run_ctrl.sv
// rtl/host_run_ctrl.sv - CPU run controller: resets, starts and times one CPU program run per accepted go.
module host_run_ctrl #(
    parameter int RST_CYCLES = 2,
    parameter int MAX_CYCLES = 10000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        go,
    input  logic [1:0]  prog_id,
    input  logic        cpu_done,
    output logic        cpu_reset,
    output logic        cpu_start,
    output logic [1:0]  prog_sel,
    output logic        busy,
    output logic        result_valid,
    output logic        timeout,
    output logic [15:0] cycle_count,
    output logic [7:0]  run_count
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_RST   = 3'd1,
        S_START = 3'd2,
        S_RUN   = 3'd3,
        S_DONE  = 3'd4
    } state_t;

    localparam logic [3:0]  RST_LAST = 4'(RST_CYCLES - 1);
    localparam logic [15:0] RUN_LAST = 16'(MAX_CYCLES - 1);

    state_t      state_q, state_d;
    logic [3:0]  rst_cnt_q, rst_cnt_d;
    logic [1:0]  prog_sel_q, prog_sel_d;
    logic        timeout_q, timeout_d;
    logic [15:0] cycle_count_q, cycle_count_d;
    logic [7:0]  run_count_q, run_count_d;
    logic        cpu_reset_q, cpu_reset_d;
    logic        cpu_start_q, cpu_start_d;
    logic        busy_q, busy_d;
    logic        result_valid_q, result_valid_d;

    always_comb begin
        state_d       = state_q;
        rst_cnt_d     = rst_cnt_q;
        prog_sel_d    = prog_sel_q;
        timeout_d     = timeout_q;
        cycle_count_d = cycle_count_q;
        run_count_d   = run_count_q;
        case (state_q)
            S_IDLE: begin
                if (go) begin
                    state_d       = S_RST;
                    rst_cnt_d     = 4'd0;
                    prog_sel_d    = prog_id;
                    timeout_d     = 1'b0;
                    cycle_count_d = 16'd0;
                end
            end
            S_RST: begin
                if (rst_cnt_q == RST_LAST) begin
                    state_d = S_START;
                end else begin
                    rst_cnt_d = rst_cnt_q + 4'd1;
                end
            end
            S_START: state_d = S_RUN;
            S_RUN: begin
                cycle_count_d = cycle_count_q + 16'd1;
                // A completion in the limit cycle is still a normal finish.
                if (cpu_done) begin
                    state_d     = S_DONE;
                    run_count_d = run_count_q + 8'd1;
                end else if (cycle_count_q == RUN_LAST) begin
                    state_d     = S_DONE;
                    timeout_d   = 1'b1;
                    run_count_d = run_count_q + 8'd1;
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Strobes are registered from the next state so they align with the state they describe.
    always_comb begin
        cpu_reset_d    = (state_d == S_RST);
        cpu_start_d    = (state_d == S_START);
        busy_d         = (state_d != S_IDLE);
        result_valid_d = (state_d == S_DONE);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q        <= S_IDLE;
            rst_cnt_q      <= 4'd0;
            prog_sel_q     <= 2'd0;
            timeout_q      <= 1'b0;
            cycle_count_q  <= 16'd0;
            run_count_q    <= 8'd0;
            cpu_reset_q    <= 1'b1;
            cpu_start_q    <= 1'b0;
            busy_q         <= 1'b0;
            result_valid_q <= 1'b0;
        end else begin
            state_q        <= state_d;
            rst_cnt_q      <= rst_cnt_d;
            prog_sel_q     <= prog_sel_d;
            timeout_q      <= timeout_d;
            cycle_count_q  <= cycle_count_d;
            run_count_q    <= run_count_d;
            cpu_reset_q    <= cpu_reset_d;
            cpu_start_q    <= cpu_start_d;
            busy_q         <= busy_d;
            result_valid_q <= result_valid_d;
        end
    end

    assign cpu_reset    = cpu_reset_q;
    assign cpu_start    = cpu_start_q;
    assign prog_sel     = prog_sel_q;
    assign busy         = busy_q;
    assign result_valid = result_valid_q;
    assign timeout      = timeout_q;
    assign cycle_count  = cycle_count_q;
    assign run_count    = run_count_q;

endmodule

// File: doc/host_run_ctrl.md
HOST_RUN_CTRL -- requirements
Module: host_run_ctrl

Interface
- REQ-001: Parameter RST_CYCLES, default 2, number of cycles cpu_reset is held per run (legal 1..15).
- REQ-002: Parameter MAX_CYCLES, default 10000, RUN-state cycle limit before timeout (legal 1..65535).
- REQ-003: clk  input  1  rising-edge clock shared with the CPU.
- REQ-004: reset  input  1  reset, synchronous, active-high.
- REQ-005: go  input  1  run request; sampled only in IDLE.
- REQ-006: prog_id  input  2  program selector; latched on an accepted go.
- REQ-007: cpu_done  input  1  CPU completion flag (level; cleared by the CPU on cpu_reset/cpu_start).
- REQ-008: cpu_reset  output  1  reset to the CPU.
- REQ-009: cpu_start  output  1  start pulse to the CPU.
- REQ-010: prog_sel  output  2  latched prog_id, stable from acceptance until the next accepted go.
- REQ-011: busy  output  1  high in every state except IDLE.
- REQ-012: result_valid  output  1  one-cycle pulse marking end of a run.
- REQ-013: timeout  output  1  high if the last run hit MAX_CYCLES; held until the next accepted go.
- REQ-014: cycle_count  output  16  RUN cycles taken by the last or current run.
- REQ-015: run_count  output  8  completed runs, including timed-out runs.

Function
- REQ-016: FSM states are IDLE, RST, START, RUN and DONE; all outputs are registered or decoded from the state register only, with no combinational path from any input to any output.
- REQ-017: IDLE: go=1 accepts a run; next state RST, prog_sel<=prog_id, timeout<=0, cycle_count<=0; go=0 stays in IDLE.
- REQ-018: RST: cpu_reset=1 for exactly RST_CYCLES consecutive cycles (internal 4-bit counter), then START.
- REQ-019: START: cpu_start=1 and cpu_reset=0 for exactly 1 cycle, then RUN.
- REQ-020: RUN: cycle_count increments by 1 every cycle; cpu_done is sampled only in RUN; cpu_done is ignored in IDLE, RST, START and DONE.
- REQ-021: RUN exit on done: cpu_done=1 -> DONE, timeout stays 0.
- REQ-022: RUN exit on limit: the cycle where cycle_count==MAX_CYCLES-1 and cpu_done=0 -> DONE, timeout<=1, cycle_count ends at MAX_CYCLES.
- REQ-023: If cpu_done=1 and the limit occur in the same cycle, done wins: timeout=0, cycle_count=MAX_CYCLES.
- REQ-024: DONE: result_valid=1 for 1 cycle, run_count increments (255 wraps to 0), then IDLE.
- REQ-025: go asserted in any state other than IDLE is ignored and is not queued.
- REQ-026: go held high continuously starts back-to-back runs; the minimum run period is RST_CYCLES+4 cycles (IDLE+RST+START+RUN>=1+DONE).
- REQ-027: cpu_reset=0 in IDLE, START, RUN and DONE, so CPU state and memory are preserved for readback after a run.
- REQ-028: cycle_count and timeout hold their values through DONE and IDLE until the next accepted go.

Reset
- REQ-029: reset=1 at a clock edge: state<=IDLE, cpu_reset=1, cpu_start=0, busy=0, result_valid=0, timeout=0, cycle_count=0, run_count=0, prog_sel=0.
- REQ-030: On the first edge with reset=0, the block is in IDLE with cpu_reset=0; a go sampled at that edge is accepted.
- REQ-031: reset asserted mid-run (any state) aborts the run: no result_valid and no run_count increment.
- REQ-032: reset has priority over go and cpu_done.

Verification
- REQ-033: Reset, then go=1 for 1 cycle with prog_id=2 -> cpu_reset high for exactly 2 cycles, then cpu_start high for 1 cycle, prog_sel=2, busy high throughout.
- REQ-034: cpu_done raised on the 5th RUN cycle -> result_valid pulse 1 cycle later, cycle_count=5, timeout=0, run_count=1.
- REQ-035: MAX_CYCLES=8, cpu_done never raised -> timeout=1, cycle_count=8, result_valid pulses once, run_count increments.
- REQ-036: MAX_CYCLES=8, cpu_done raised on the 8th RUN cycle -> timeout=0, cycle_count=8.
- REQ-037: go held high for 3 full runs with cpu_done=1 throughout RUN -> run_count=3, period RST_CYCLES+4, and a stale cpu_done during RST/START never ends a run early.
- REQ-038: reset asserted during RUN, then 256 completed runs -> no result_valid from the aborted run, and run_count wraps 255->0.
